// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared FSM states, iteration constants and reset values for mult_div_unit
package mult_div_pkg;
  typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, DONE} state_t;
  localparam int ITER_CNT = 32;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(ITER_CNT - 1);
  localparam state_t RST_STATE = IDLE;
  localparam logic [CNT_W-1:0] RST_CNT = '0;
  localparam logic RST_PULSE = 1'b0;
endpackage

// File: rtl/mult_div_unit_div_core.sv
// div_core: restoring-division datapath on magnitudes with sign fix-up of the next-step result
module div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] q_res,
  output logic [DATA_W-1:0] r_res
);
  logic [DATA_W-1:0] rem, quot, a_mag, b_mag, rem_nx, quot_nx;
  logic [DATA_W:0] dvs, rem_sh, diff;
  logic neg_q, neg_r, ge;
  always_comb begin
    a_mag = a[DATA_W-1] ? -a : a;
    b_mag = b[DATA_W-1] ? -b : b;
    rem_sh = {rem, quot[DATA_W-1]};
    diff = rem_sh - dvs;
    // trial difference stays within +/-2^(W-1), so its top bit is a valid sign
    ge = ~diff[DATA_W];
    rem_nx = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quot_nx = {quot[DATA_W-2:0], ge};
    q_res = neg_q ? -quot_nx : quot_nx;
    r_res = neg_r ? -rem_nx : rem_nx;
  end
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      rem <= '0;
      quot <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      rem <= '0;
      quot <= a_mag;
      dvs <= {1'b0, b_mag};
      neg_q <= a[DATA_W-1] ^ b[DATA_W-1];
      neg_r <= a[DATA_W-1];
    end else if (step) begin
      rem <= rem_nx;
      quot <= quot_nx;
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed MULT (radix-2 Booth) / DIV (restoring) unit with HI/LO result pairs
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              mult_init,
  input  logic              div_init,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] mult_hi,
  output logic [DATA_W-1:0] mult_lo,
  output logic [DATA_W-1:0] div_hi,
  output logic [DATA_W-1:0] div_lo,
  output logic              mult_stop,
  output logic              div_stop,
  output logic              div_zero
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic last, mult_ld, div_ld, zero_hit, mult_fin, div_fin, div_step;
  logic [DATA_W:0] mcand, m_add, sum;
  logic [2*DATA_W:0] acc, acc_nx;
  logic [DATA_W-1:0] q_res, r_res;
  assign last = cnt == LAST_IT;
  always_ff @(posedge clk) state <= !reset_in ? RST_STATE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? (mult_init ? MULT_RUN : div_init ? (|b_in ? DIV_RUN : DONE) : IDLE)
             : state == DONE ? IDLE : last ? DONE : state;
  end
  always_comb begin
    mult_ld = state == IDLE && mult_init;
    div_ld = state == IDLE && !mult_init && div_init && |b_in;
    zero_hit = state == IDLE && !mult_init && div_init && ~|b_in;
    mult_fin = state == MULT_RUN && last;
    div_fin = state == DIV_RUN && last;
    div_step = state == DIV_RUN;
  end
  // acc = {hi, lo, q-1}; the add is one bit wider so -2^31 multiplicands cannot overflow
  always_comb begin
    m_add = acc[1:0] == 2'b01 ? mcand : acc[1:0] == 2'b10 ? -mcand : '0;
    sum = {acc[2*DATA_W], acc[2*DATA_W:DATA_W+1]} + m_add;
    acc_nx = {sum, acc[DATA_W:1]};
  end
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      cnt <= RST_CNT;
      acc <= '0;
      mcand <= '0;
      mult_hi <= '0;
      mult_lo <= '0;
      div_hi <= '0;
      div_lo <= '0;
      mult_stop <= RST_PULSE;
      div_stop <= RST_PULSE;
      div_zero <= RST_PULSE;
    end else begin
      cnt <= (mult_ld || div_ld) ? RST_CNT : (state inside {MULT_RUN, DIV_RUN}) ? cnt + 1'b1 : cnt;
      mult_stop <= mult_fin;
      div_stop <= div_fin || zero_hit;
      div_zero <= zero_hit;
      if (mult_ld) begin
        acc <= {{DATA_W{1'b0}}, b_in, 1'b0};
        mcand <= {a_in[DATA_W-1], a_in};
      end else if (state == MULT_RUN) acc <= acc_nx;
      if (mult_fin) begin
        mult_hi <= acc_nx[2*DATA_W:DATA_W+1];
        mult_lo <= acc_nx[DATA_W:1];
      end
      if (div_fin) begin
        div_hi <= r_res;
        div_lo <= q_res;
      end
    end
  end
  div_core #(.DATA_W(DATA_W)) u_div (
    .clk(clk),
    .reset_in(reset_in),
    .load(div_ld),
    .step(div_step),
    .a(a_in),
    .b(b_in),
    .q_res(q_res),
    .r_res(r_res)
  );
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  logic clk = 0, reset_in = 0, mult_init = 0, div_init = 0;
  logic [31:0] a_in = 0, b_in = 0, mult_hi, mult_lo, div_hi, div_lo;
  logic mult_stop, div_stop, div_zero, seen;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  mult_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset_in(reset_in), .mult_init(mult_init), .div_init(div_init),
    .a_in(a_in), .b_in(b_in), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo), .mult_stop(mult_stop),
    .div_stop(div_stop), .div_zero(div_zero)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic tick_n(input int n, output logic any);
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      any = any | mult_stop | div_stop | div_zero;
    end
  endtask
  task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    mult_init = m;
    div_init = d;
    a_in = a;
    b_in = b;
    tick();
    mult_init = 0;
    div_init = 0;
    a_in = $urandom;
    b_in = $urandom;
  endtask
  task automatic run_out(input string tag);
    logic early;
    tick_n(31, early);
    chk({tag, "_no_early_stop"}, early, 1'b0);
    tick();
  endtask
  initial begin
    tick();
    tick();
    chk("rst_mult_hi", mult_hi, 0);
    chk("rst_mult_lo", mult_lo, 0);
    chk("rst_div_hi", div_hi, 0);
    chk("rst_div_lo", div_lo, 0);
    chk("rst_stops", {mult_stop, div_stop, div_zero}, 0);
    reset_in = 1;
    tick();
    start(1, 0, 32'd7, -32'sd3);
    chk("m1_stop_e0", mult_stop, 0);
    run_out("m1");
    chk("m1_stop", mult_stop, 1);
    chk("m1_hi", mult_hi, 32'hFFFFFFFF);
    chk("m1_lo", mult_lo, 32'hFFFFFFEB);
    tick();
    chk("m1_stop_drop", mult_stop, 0);
    start(1, 0, 32'h80000000, 32'h80000000);
    run_out("m2");
    chk("m2_stop", mult_stop, 1);
    chk("m2_hi", mult_hi, 32'h40000000);
    chk("m2_lo", mult_lo, 0);
    tick();
    start(0, 1, -32'sd7, 32'd2);
    run_out("d1");
    chk("d1_stop", {div_stop, div_zero, mult_stop}, 3'b100);
    chk("d1_lo", div_lo, 32'hFFFFFFFD);
    chk("d1_hi", div_hi, 32'hFFFFFFFF);
    chk("d1_mult_hi_kept", mult_hi, 32'h40000000);
    chk("d1_mult_lo_kept", mult_lo, 0);
    tick();
    start(0, 1, 32'd5, 32'd0);
    chk("dz_pulse", {div_stop, div_zero}, 2'b11);
    chk("dz_lo_kept", div_lo, 32'hFFFFFFFD);
    chk("dz_hi_kept", div_hi, 32'hFFFFFFFF);
    tick();
    chk("dz_drop", {div_stop, div_zero}, 2'b00);
    start(0, 1, 32'd7, -32'sd2);
    run_out("d2");
    chk("d2_stop", div_stop, 1);
    chk("d2_lo", div_lo, 32'hFFFFFFFD);
    chk("d2_hi", div_hi, 32'd1);
    tick();
    start(0, 1, 32'h80000000, 32'hFFFFFFFF);
    run_out("d3");
    chk("d3_lo", div_lo, 32'h80000000);
    chk("d3_hi", div_hi, 0);
    tick();
    start(1, 1, 32'd4, 32'd5);
    tick_n(9, seen);
    div_init = 1;
    b_in = 32'd3;
    tick();
    div_init = 0;
    tick_n(21, seen);
    chk("both_no_early", seen, 0);
    tick();
    chk("both_stops", {mult_stop, div_stop}, 2'b10);
    chk("both_lo", mult_lo, 32'd20);
    chk("both_hi", mult_hi, 0);
    tick_n(40, seen);
    chk("both_no_div_stop", seen, 0);
    start(0, 1, 32'd100, 32'd3);
    tick_n(14, seen);
    reset_in = 0;
    tick();
    reset_in = 1;
    chk("mr_mult_hi", mult_hi, 0);
    chk("mr_mult_lo", mult_lo, 0);
    chk("mr_div_hi", div_hi, 0);
    chk("mr_div_lo", div_lo, 0);
    chk("mr_stops", {mult_stop, div_stop, div_zero}, 0);
    tick_n(40, seen);
    chk("mr_no_stop", seen, 0);
    start(1, 0, 32'd2, 32'd3);
    run_out("m3");
    chk("m3_stop", mult_stop, 1);
    chk("m3_lo", mult_lo, 32'd6);
    chk("m3_hi", mult_hi, 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
